// File: rtl/channel_deserializer_pkg.sv
// Shared helpers for the channel deserializer slice.
// Holds width arithmetic used when sizing index counters.
package channel_deserializer_pkg;

    // Width of a 0..k-1 index, never less than one bit.
    function automatic int idx_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/channel_if.sv
// Channel: valid/data-acknowledge link of width N.
// Signals: v (valid), d (data), a (acknowledge from receiver).
interface Channel #(
    parameter int N = 8
);
    logic         v;
    logic [N-1:0] d;
    logic         a;

    modport sender   (output v, output d, input  a);
    modport receiver (input  v, input  d, output a);
endinterface

// File: rtl/channel_out_reg.sv
// Single-entry holding register driving a Channel output.
// Ports: clk, reset (async, active-high), load, data -> out;
// ready = register can take a new word this cycle.
module channel_out_reg
    import channel_deserializer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] data,
    Channel.sender       out,
    output logic         ready
);

    logic         v_q, v_d;
    logic [N-1:0] d_q, d_d;

    // Load overrides the acknowledge so a word can be replaced
    // in the same cycle the previous one is taken.
    always_comb begin
        v_d = v_q & ~out.a;
        d_d = d_q;
        if (load) begin
            v_d = 1'b1;
            d_d = data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign out.v = v_q;
    assign out.d = d_q;
    assign ready = ~v_q | out.a;

endmodule

// File: rtl/channel_deserializer.sv
// Reassembles K NIn-bit chunks into one NIn*K-bit word,
// first chunk in the LSBs.
// Ports: clk, reset (async, active-high), in (chunk Channel),
// out (word Channel), clear (drop partial word),
// partial (1..K-1 chunks held).
module channel_deserializer
    import channel_deserializer_pkg::*;
#(
    parameter int NIn = 8,
    parameter int K   = 4
) (
    input  logic    clk,
    input  logic    reset,
    Channel.receiver in,
    Channel.sender   out,
    input  logic    clear,
    output logic    partial
);

    localparam int NOut = NIn * K;
    localparam int IdxW = idx_width(K);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(K - 1);

    logic [IdxW-1:0] idx_q, idx_d;
    logic            last;
    logic            xfer;
    logic            load;
    logic            o_ready;
    logic [NOut-1:0] word;

    assign last = (idx_q == LastIdx);

    // Only the completing chunk needs room in the output register.
    assign in.a = ~reset & in.v & ~clear & (~last | o_ready);
    assign xfer = in.v & in.a;
    assign load = xfer & last;

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (xfer) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    generate
        if (K > 1) begin : g_asm
            localparam int AsmW = (K - 1) * NIn;
            logic [AsmW-1:0] asm_q, asm_d;

            always_comb begin
                asm_d = asm_q;
                if (xfer & ~last) begin
                    asm_d[NIn*int'(idx_q) +: NIn] = in.d;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    asm_q <= '0;
                end else begin
                    asm_q <= asm_d;
                end
            end

            assign word = {in.d, asm_q};
        end else begin : g_pass
            assign word = in.d;
        end
    endgenerate

    channel_out_reg #(
        .N (NOut)
    ) u_out_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .data  (word),
        .out   (out),
        .ready (o_ready)
    );

    assign partial = (idx_q != '0);

endmodule

// File: tb/tb_channel_deserializer.sv
// Directed bench for channel_deserializer (NIn=8,K=4)
// plus a randomized-handshake K=1, NIn=16 instance.
module tb_channel_deserializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear0 = 1'b0;
    logic clear1 = 1'b0;
    logic partial0;
    logic partial1;

    int vectors = 0;
    int miscompares = 0;

    Channel #(8)  c_in ();
    Channel #(32) c_out ();
    Channel #(16) k_in ();
    Channel #(16) k_out ();

    always #5 clk = ~clk;

    channel_deserializer #(
        .NIn (8),
        .K   (4)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .in      (c_in),
        .out     (c_out),
        .clear   (clear0),
        .partial (partial0)
    );

    channel_deserializer #(
        .NIn (16),
        .K   (1)
    ) u_k1 (
        .clk     (clk),
        .reset   (reset),
        .in      (k_in),
        .out     (k_out),
        .clear   (clear1),
        .partial (partial1)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] wexp(input int w);
        return {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
    endfunction

    task automatic test_reset();
        c_in.v = 1'b1;
        c_in.d = 8'h5A;
        c_out.a = 1'b0;
        @(negedge clk);
        vectors++;
        if (c_in.a !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_a: got %b want 0", c_in.a);
        end
        vectors++;
        if (c_out.v !== 1'b0 || c_out.d !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_out: got v=%b d=%h want 0/0",
                     c_out.v, c_out.d);
        end
        vectors++;
        if (partial0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_partial: got %b want 0", partial0);
        end
        c_in.v = 1'b0;
        c_in.d = 'x;
        reset = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ch [4];
        ch[0] = 8'h11; ch[1] = 8'h22;
        ch[2] = 8'h33; ch[3] = 8'h44;
        c_out.a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_in.v = 1'b1;
            c_in.d = ch[i];
            #1;
            vectors++;
            if (c_in.a !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_in_a[%0d]: got %b want 1", i, c_in.a);
            end
            step();
            if (i == 1) begin
                vectors++;
                if (partial0 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_partial: got %b want 1", partial0);
                end
            end
        end
        c_in.v = 1'b0;
        c_in.d = 'x;
        vectors++;
        if (c_out.v !== 1'b1 || c_out.d !== 32'h44332211) begin
            miscompares++;
            $display("FAIL b2b_word: got v=%b d=%h want 1/44332211",
                     c_out.v, c_out.d);
        end
        step();
        vectors++;
        if (c_out.v !== 1'b0 || partial0 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_onecycle: got v=%b p=%b want 0/0",
                     c_out.v, partial0);
        end
    endtask

    task automatic test_stream();
        c_out.a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (i % 4 == 0 && i > 0) begin
                if (c_out.v !== 1'b1 || c_out.d !== wexp(i/4 - 1)) begin
                    miscompares++;
                    $display("FAIL stream_word[%0d]: got v=%b d=%h want 1/%h",
                             i/4 - 1, c_out.v, c_out.d, wexp(i/4 - 1));
                end
            end else if (c_out.v !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_gap[%0d]: got v=%b want 0", i, c_out.v);
            end
            c_in.v = 1'b1;
            c_in.d = 8'(i + 1);
            #1;
            vectors++;
            if (c_in.a !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_in_a[%0d]: got %b want 1", i, c_in.a);
            end
            step();
        end
        c_in.v = 1'b0;
        c_in.d = 'x;
        vectors++;
        if (c_out.v !== 1'b1 || c_out.d !== wexp(2)) begin
            miscompares++;
            $display("FAIL stream_word[2]: got v=%b d=%h want 1/%h",
                     c_out.v, c_out.d, wexp(2));
        end
        step();
    endtask

    task automatic test_backpressure();
        c_out.a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            c_in.v = 1'b1;
            c_in.d = 8'(i + 1);
            #1;
            vectors++;
            if (c_in.a !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_in_a[%0d]: got %b want 1", i, c_in.a);
            end
            step();
        end
        c_in.d = 8'h08;
        #1;
        vectors++;
        if (c_in.a !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stall: got in_a=%b want 0", c_in.a);
        end
        step();
        vectors++;
        if (c_out.v !== 1'b1 || c_out.d !== 32'h04030201 ||
            c_in.a !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold: got v=%b d=%h a=%b want 1/04030201/0",
                     c_out.v, c_out.d, c_in.a);
        end
        c_out.a = 1'b1;
        #1;
        vectors++;
        if (c_in.a !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got in_a=%b want 1", c_in.a);
        end
        step();
        c_in.v = 1'b0;
        c_in.d = 'x;
        vectors++;
        if (c_out.v !== 1'b1 || c_out.d !== 32'h08070605) begin
            miscompares++;
            $display("FAIL bp_word2: got v=%b d=%h want 1/08070605",
                     c_out.v, c_out.d);
        end
        step();
        vectors++;
        if (c_out.v !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: got v=%b want 0", c_out.v);
        end
    endtask

    task automatic test_clear();
        logic [7:0] ch [4];
        ch[0] = 8'hCC; ch[1] = 8'hDD;
        ch[2] = 8'hEE; ch[3] = 8'hFF;
        c_out.a = 1'b1;
        c_in.v = 1'b1;
        c_in.d = 8'hAA;
        step();
        c_in.d = 8'hBB;
        step();
        c_in.d = 8'hCC;
        clear0 = 1'b1;
        #1;
        vectors++;
        if (c_in.a !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_block: got in_a=%b want 0", c_in.a);
        end
        step();
        clear0 = 1'b0;
        vectors++;
        if (partial0 !== 1'b0 || c_out.v !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_state: got p=%b v=%b want 0/0",
                     partial0, c_out.v);
        end
        for (int i = 0; i < 4; i++) begin
            c_in.d = ch[i];
            step();
        end
        c_in.v = 1'b0;
        c_in.d = 'x;
        vectors++;
        if (c_out.v !== 1'b1 || c_out.d !== 32'hFFEEDDCC) begin
            miscompares++;
            $display("FAIL clr_word: got v=%b d=%h want 1/FFEEDDCC",
                     c_out.v, c_out.d);
        end
        step();
    endtask

    task automatic test_reset_mid();
        c_out.a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            c_in.v = 1'b1;
            c_in.d = 8'(i + 1);
            step();
        end
        vectors++;
        if (c_out.v !== 1'b1 || partial0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_pre: got v=%b p=%b want 1/1",
                     c_out.v, partial0);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (c_out.v !== 1'b0 || partial0 !== 1'b0 || c_in.a !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_async: got v=%b p=%b a=%b want 0/0/0",
                     c_out.v, partial0, c_in.a);
        end
        step();
        reset = 1'b0;
        c_out.a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_in.d = 8'(8'h10 + i);
            step();
        end
        c_in.v = 1'b0;
        c_in.d = 'x;
        vectors++;
        if (c_out.v !== 1'b1 || c_out.d !== 32'h13121110) begin
            miscompares++;
            $display("FAIL rmid_word: got v=%b d=%h want 1/13121110",
                     c_out.v, c_out.d);
        end
        step();
    endtask

    task automatic test_k1_random();
        logic [15:0] exp_q [$];
        int n_sent = 0;
        int n_recv = 0;
        logic holding = 1'b0;
        localparam int NTot = 24;
        for (int cyc = 0; cyc < 3000 && n_recv < NTot; cyc++) begin
            if (!holding) begin
                if (n_sent < NTot && $urandom_range(0, 2) != 0) begin
                    k_in.v = 1'b1;
                    k_in.d = 16'($urandom);
                    holding = 1'b1;
                end else begin
                    k_in.v = 1'b0;
                    k_in.d = 'x;
                end
            end
            k_out.a = ($urandom_range(0, 3) != 0);
            #2;
            if (k_out.v && k_out.a) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL k1_extra: got %h want none", k_out.d);
                end else begin
                    if (k_out.d !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL k1_data[%0d]: got %h want %h",
                                 n_recv, k_out.d, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                n_recv++;
            end
            if (holding && k_in.a) begin
                exp_q.push_back(k_in.d);
                n_sent++;
                holding = 1'b0;
            end
            @(negedge clk);
        end
        k_in.v = 1'b0;
        k_in.d = 'x;
        k_out.a = 1'b0;
        vectors++;
        if (n_recv != NTot) begin
            miscompares++;
            $display("FAIL k1_count: got %0d want %0d", n_recv, NTot);
        end
    endtask

    initial begin
        c_in.v = 1'b0;
        c_in.d = 'x;
        c_out.a = 1'b0;
        k_in.v = 1'b0;
        k_in.d = 'x;
        k_out.a = 1'b0;
        test_reset();
        test_back_to_back();
        test_stream();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_k1_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
